// File: rtl/equiv_stim_misr.sv
// Equivalence-run harness: LFSR stimulus shared by a golden and a synthesized DUT,
// per-vector response compare and one MISR signature per response bus.
//
// state   | meaning
// S_IDLE  | after reset, waiting for start
// S_RUN   | issuing one LFSR vector per clock
// S_DRAIN | all vectors issued, waiting for the last responses to be compared
// S_DONE  | results held until the next start
module equiv_stim_misr #(
   parameter int               IN_W     = 57,
   parameter int               OUT_W    = 605,
   parameter int               NUM_VEC  = 20,
   parameter int               DUT_LAT  = 1,
   parameter logic [63:0]      SEED     = 64'h729042712bb0e91b,
   parameter int               SIG_W    = 32,
   parameter logic [SIG_W-1:0] SIG_POLY = 32'h04C11DB7,
   parameter int               CW       = $clog2(NUM_VEC + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [IN_W-1:0]  stim,
   input  logic [OUT_W-1:0] y_ref,
   input  logic [OUT_W-1:0] y_dut,
   output logic             busy,
   output logic             done,
   output logic             mismatch,
   output logic [CW-1:0]    first_fail_idx,
   output logic [CW-1:0]    vec_cnt,
   output logic [SIG_W-1:0] sig_ref,
   output logic [SIG_W-1:0] sig_dut
);

   localparam logic [63:0]   SEED_EFF  = (SEED == 64'h0) ? 64'h1 : SEED;
   localparam logic [63:0]   LFSR_TAPS = 64'hD800000000000000;
   localparam logic [CW-1:0] LAST_IDX  = CW'(NUM_VEC - 1);
   localparam int            NCHUNK    = (OUT_W + SIG_W - 1) / SIG_W;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [63:0]        r_lfsr;
   logic [CW-1:0]      r_issue_cnt;
   logic [CW-1:0]      r_vec_cnt;
   logic [CW-1:0]      r_first_fail;
   logic               r_mismatch;
   logic [SIG_W-1:0]   r_sig_ref;
   logic [SIG_W-1:0]   r_sig_dut;
   logic               w_start;
   logic               w_issue;
   logic               w_cmp;

   // XOR of all SIG_W-bit chunks; the top chunk is zero-padded
   function automatic logic [SIG_W-1:0] fold(input logic [OUT_W-1:0] y);
      logic [NCHUNK*SIG_W-1:0] p;
      p = '0;
      p[OUT_W-1:0] = y;
      fold = '0;
      for (int i = 0; i < NCHUNK; i++) fold = fold ^ p[i*SIG_W +: SIG_W];
   endfunction

   function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                  input logic [OUT_W-1:0] y);
      misr_step = {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? SIG_POLY : '0) ^ fold(y);
   endfunction

   assign w_start = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_issue = (r_state == S_RUN);

   generate
      if (DUT_LAT == 0) begin : g_nolat
         assign w_cmp = w_issue;
      end else begin : g_lat
         logic [DUT_LAT-1:0] r_vpipe;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_vpipe <= '0;
            end else begin
               r_vpipe[0] <= w_issue;
               for (int i = 1; i < DUT_LAT; i++) r_vpipe[i] <= r_vpipe[i-1];
            end
         end
         assign w_cmp = r_vpipe[DUT_LAT-1];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (start) w_state_nxt = S_RUN;
         S_RUN: begin
            if (r_issue_cnt == LAST_IDX) w_state_nxt = (DUT_LAT == 0) ? S_DONE : S_DRAIN;
         end
         S_DRAIN: if (w_cmp && (r_vec_cnt == LAST_IDX)) w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         S_RUN, S_DRAIN: busy = 1'b1;
         S_DONE:         done = 1'b1;
         default:        ;
      endcase
   end

   // Stimulus generator: the final vector stays on the bus once issuing stops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lfsr      <= SEED_EFF;
         r_issue_cnt <= '0;
      end else if (w_start) begin
         r_lfsr      <= SEED_EFF;
         r_issue_cnt <= '0;
      end else if (w_issue) begin
         r_issue_cnt <= r_issue_cnt + CW'(1);
         if (r_issue_cnt != LAST_IDX)
            r_lfsr <= {1'b0, r_lfsr[63:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 64'h0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vec_cnt    <= '0;
         r_first_fail <= '0;
         r_mismatch   <= 1'b0;
         r_sig_ref    <= '0;
         r_sig_dut    <= '0;
      end else if (w_start) begin
         r_vec_cnt    <= '0;
         r_first_fail <= '0;
         r_mismatch   <= 1'b0;
         r_sig_ref    <= '0;
         r_sig_dut    <= '0;
      end else if (w_cmp) begin
         r_vec_cnt <= r_vec_cnt + CW'(1);
         r_sig_ref <= misr_step(r_sig_ref, y_ref);
         r_sig_dut <= misr_step(r_sig_dut, y_dut);
         if ((y_ref != y_dut) && !r_mismatch) begin
            r_mismatch   <= 1'b1;
            r_first_fail <= r_vec_cnt;
         end
      end
   end

   assign stim           = r_lfsr[IN_W-1:0];
   assign mismatch       = r_mismatch;
   assign first_fail_idx = r_first_fail;
   assign vec_cnt        = r_vec_cnt;
   assign sig_ref        = r_sig_ref;
   assign sig_dut        = r_sig_dut;

endmodule
